// File: rtl/avst2axis_bridge.sv
// avst2axis_bridge
//   Avalon-ST sink to AXI4-Stream source bridge. Accepts multi-symbol
//   Avalon beats under a configurable ready latency, buffers them in a
//   credit-protected skid FIFO and presents them as AXI-Stream beats.
//   Framing is checked: beats outside a packet are dropped and counted,
//   and truncated packets or an out-of-range empty raise proto_err.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   av_sop     in   start of packet (qualified by av_dval)
//   av_eop     in   end of packet (qualified by av_dval)
//   av_data    in   beat data, first symbol in MSBs
//   av_empty   in   unused LS symbols on the eop beat
//   av_err     in   packet error, sampled on the eop beat
//   av_dval    in   beat valid
//   av_rdy     out  sink ready (combinational credit check)
//   axi_data   out  stream data, same symbol order as av_data
//   axi_keep   out  byte enables, MSB = first symbol
//   axi_user   out  error flag, meaningful with axi_last
//   axi_last   out  last beat of packet
//   axi_valid  out  beat valid
//   axi_rdy    in   downstream ready
//   proto_err  out  one-cycle pulse on framing violation
//   drop_cnt   out  saturating count of dropped beats

module avst2axis_bridge #(
    parameter int unsigned SYMBOLS       = 4,
    parameter int unsigned EMPTYWIDTH    = 2,
    parameter int unsigned READY_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned FIFO_IDX_LEN  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    av_sop,
    input  logic                    av_eop,
    input  logic [8*SYMBOLS-1:0]    av_data,
    input  logic [EMPTYWIDTH-1:0]   av_empty,
    input  logic                    av_err,
    input  logic                    av_dval,
    output logic                    av_rdy,
    output logic [8*SYMBOLS-1:0]    axi_data,
    output logic [SYMBOLS-1:0]      axi_keep,
    output logic                    axi_user,
    output logic                    axi_last,
    output logic                    axi_valid,
    input  logic                    axi_rdy,
    output logic                    proto_err,
    output logic [15:0]             drop_cnt
);

    localparam int unsigned DW = 8 * SYMBOLS;
    localparam logic [SYMBOLS-1:0]      KEEP_ALL = '1;
    localparam logic [FIFO_IDX_LEN:0]   PTR_ONE  = 1;

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    state_t                     state_q, state_d;
    logic [FIFO_IDX_LEN:0]      head_q, head_d;
    logic [FIFO_IDX_LEN:0]      tail_q, tail_d;
    logic [READY_LATENCY-1:0]   rdy_hist_q, rdy_hist_d;
    logic [15:0]                drop_cnt_q, drop_cnt_d;
    logic                       proto_err_q, proto_err_d;

    logic [DW-1:0]              mem_data_q [FIFO_DEPTH];
    logic [SYMBOLS-1:0]         mem_keep_q [FIFO_DEPTH];
    logic                       mem_last_q [FIFO_DEPTH];
    logic                       mem_user_q [FIFO_DEPTH];

    logic [FIFO_IDX_LEN:0]      count;
    logic [FIFO_IDX_LEN-1:0]    head_idx;
    logic [FIFO_IDX_LEN-1:0]    tail_idx;
    logic [31:0]                inflight;
    logic [SYMBOLS-1:0]         keep_w;
    logic                       empty_ovf;
    logic                       push;
    logic                       pop;
    logic                       drop;
    logic                       frame_err;

    assign count    = tail_q - head_q;
    assign head_idx = head_q[FIFO_IDX_LEN-1:0];
    assign tail_idx = tail_q[FIFO_IDX_LEN-1:0];

    // Credit check: beats already granted but not yet arrived are counted
    // against the free space; pops are ignored, so this is conservative.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i + 1 < READY_LATENCY; i++) begin
            inflight = inflight + 32'(rdy_hist_q[i]);
        end
        av_rdy = (32'(count) + 32'(av_dval) + inflight) < 32'(FIFO_DEPTH);
    end

    always_comb begin
        rdy_hist_d    = rdy_hist_q << 1;
        rdy_hist_d[0] = av_rdy;
    end

    // Byte enables from av_empty; an empty count that covers the whole beat
    // is reported as a framing error and yields no valid bytes.
    always_comb begin
        keep_w    = KEEP_ALL;
        empty_ovf = 1'b0;
        if (av_eop) begin
            if (32'(av_empty) >= 32'(SYMBOLS)) begin
                keep_w    = '0;
                empty_ovf = av_dval;
            end else begin
                keep_w = KEEP_ALL << av_empty;
            end
        end
    end

    // Framing FSM
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        drop      = 1'b0;
        frame_err = 1'b0;
        if (av_dval) begin
            unique case (state_q)
                IDLE: begin
                    if (av_sop) begin
                        push = 1'b1;
                        if (!av_eop) begin
                            state_d = PKT;
                        end
                    end else begin
                        drop      = 1'b1;
                        frame_err = 1'b1;
                    end
                end
                PKT: begin
                    push = 1'b1;
                    // sop inside a packet truncates the previous one; the
                    // beat is kept as the start of the next packet.
                    if (av_sop) begin
                        frame_err = 1'b1;
                    end
                    if (av_eop) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    assign pop = axi_valid && axi_rdy;

    always_comb begin
        head_d      = pop  ? head_q + PTR_ONE : head_q;
        tail_d      = push ? tail_q + PTR_ONE : tail_q;
        proto_err_d = frame_err | empty_ovf;
        drop_cnt_d  = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            rdy_hist_q  <= '0;
            drop_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            rdy_hist_q  <= rdy_hist_d;
            drop_cnt_q  <= drop_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage needs no reset: entries are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[tail_idx] <= av_data;
            mem_keep_q[tail_idx] <= keep_w;
            mem_last_q[tail_idx] <= av_eop;
            mem_user_q[tail_idx] <= av_err && av_eop;
        end
    end

    // Head entry is gated by valid so every output reads zero when empty.
    always_comb begin
        axi_valid = (count != '0);
        axi_data  = '0;
        axi_keep  = '0;
        axi_last  = 1'b0;
        axi_user  = 1'b0;
        if (axi_valid) begin
            axi_data = mem_data_q[head_idx];
            axi_keep = mem_keep_q[head_idx];
            axi_last = mem_last_q[head_idx];
            axi_user = mem_user_q[head_idx];
        end
    end

    assign proto_err = proto_err_q;
    assign drop_cnt  = drop_cnt_q;

    src_ready_latency_a: assert property (@(posedge clk) disable iff (!rst_n)
        av_dval |-> rdy_hist_q[READY_LATENCY-1]);

    fifo_no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (32'(count) < 32'(FIFO_DEPTH)));

endmodule

// File: tb/tb_avst2axis_bridge.sv
module tb_avst2axis_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        av_sop, av_eop, av_err, av_dval, av_rdy;
    logic [31:0] av_data;
    logic [1:0]  av_empty;
    logic [31:0] axi_data;
    logic [3:0]  axi_keep;
    logic        axi_user, axi_last, axi_valid, axi_rdy;
    logic        proto_err;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    avst2axis_bridge #(
        .SYMBOLS(4), .EMPTYWIDTH(2), .READY_LATENCY(2), .FIFO_DEPTH(4), .FIFO_IDX_LEN(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .av_sop(av_sop), .av_eop(av_eop), .av_data(av_data), .av_empty(av_empty),
        .av_err(av_err), .av_dval(av_dval), .av_rdy(av_rdy),
        .axi_data(axi_data), .axi_keep(axi_keep), .axi_user(axi_user),
        .axi_last(axi_last), .axi_valid(axi_valid), .axi_rdy(axi_rdy),
        .proto_err(proto_err), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] d;
        logic [1:0]  e;
        logic        err;
    } src_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
    } exp_t;

    src_t  src_q[$];
    exp_t  exp_q[$];

    // Source-side ready history: a compliant source may only assert
    // av_dval two cycles after seeing av_rdy high.
    logic [1:0] tb_hist;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_hist <= 2'b00;
        else        tb_hist <= {tb_hist[0], av_rdy};
    end

    int    n_pass = 0;
    int    n_fail = 0;
    int    n_total = 0;
    string tname = "init";

    int cyc = 0;
    int acc, acc_before, first_dval, first_valid, first_low_acc;
    int rdy_low, pe_cnt, out_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tname, tag, obs, exp_v);
        end
    endtask

    task automatic add_src(input logic sop, input logic eop, input logic [31:0] d,
                           input logic [1:0] e, input logic err);
        src_t s;
        s.sop = sop; s.eop = eop; s.d = d; s.e = e; s.err = err;
        src_q.push_back(s);
    endtask

    task automatic add_exp(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        exp_t x;
        x.d = d; x.k = k; x.l = l; x.u = u;
        exp_q.push_back(x);
    endtask

    task automatic clr();
        acc = 0; acc_before = 0; first_dval = -1; first_valid = -1; first_low_acc = -1;
        rdy_low = 0; pe_cnt = 0; out_cnt = 0;
    endtask

    // One clock cycle: observe outputs before the edge, then drive the source
    // 1 time unit after the edge, then sample av_rdy once dval has settled.
    task automatic step();
        exp_t x;
        src_t s;
        if (proto_err === 1'b1) pe_cnt++;
        if (axi_valid === 1'b1 && axi_rdy === 1'b1) begin
            out_cnt++;
            if (first_valid < 0) first_valid = cyc;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("data", axi_data, x.d);
                chk("keep", 32'(axi_keep), 32'(x.k));
                chk("last", 32'(axi_last), 32'(x.l));
                chk("user", 32'(axi_user), 32'(x.u));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        acc_before = acc;
        if (tb_hist[1] && src_q.size() != 0) begin
            s = src_q.pop_front();
            av_dval = 1'b1; av_sop = s.sop; av_eop = s.eop;
            av_data = s.d; av_empty = s.e; av_err = s.err;
            acc++;
            if (first_dval < 0) first_dval = cyc;
        end else begin
            av_dval = 1'b0; av_sop = 1'b0; av_eop = 1'b0;
            av_data = '0; av_empty = '0; av_err = 1'b0;
        end
        #1;
        if (av_rdy === 1'b0) begin
            rdy_low++;
            if (first_low_acc < 0) first_low_acc = acc_before;
        end
    endtask

    task automatic run(input int max);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < max) begin
            step();
            n++;
        end
        chk("drain", 32'(src_q.size() == 0 && exp_q.size() == 0), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        rst_n = 1'b0; axi_rdy = 1'b0;
        av_dval = 1'b0; av_sop = 1'b0; av_eop = 1'b0;
        av_data = '0; av_empty = '0; av_err = 1'b0;
        clr();

        // Reset values
        tname = "reset";
        repeat (3) @(posedge clk);
        #1;
        chk("axi_valid", 32'(axi_valid), 32'd0);
        chk("av_rdy", 32'(av_rdy), 32'd1);
        chk("drop_cnt", 32'(drop_cnt), 32'd0);
        chk("proto_err", 32'(proto_err), 32'd0);
        chk("axi_last", 32'(axi_last), 32'd0);
        rst_n = 1'b1;
        #1;

        // 5-beat packet, sink always ready
        tname = "stream";
        axi_rdy = 1'b1;
        clr();
        add_src(1'b1, 1'b0, 32'hA000_0001, 2'd0, 1'b0);
        add_src(1'b0, 1'b0, 32'hA000_0002, 2'd0, 1'b0);
        add_src(1'b0, 1'b0, 32'hA000_0003, 2'd0, 1'b0);
        add_src(1'b0, 1'b0, 32'hA000_0004, 2'd0, 1'b0);
        add_src(1'b0, 1'b1, 32'hA000_0005, 2'd1, 1'b0);
        add_exp(32'hA000_0001, 4'hF, 1'b0, 1'b0);
        add_exp(32'hA000_0002, 4'hF, 1'b0, 1'b0);
        add_exp(32'hA000_0003, 4'hF, 1'b0, 1'b0);
        add_exp(32'hA000_0004, 4'hF, 1'b0, 1'b0);
        add_exp(32'hA000_0005, 4'b1110, 1'b1, 1'b0);
        run(40);
        idle(3);
        chk("out_cnt", 32'(out_cnt), 32'd5);
        chk("latency", 32'(first_valid - first_dval), 32'd1);
        chk("rdy_low", 32'(rdy_low), 32'd0);
        chk("pe_cnt", 32'(pe_cnt), 32'd0);

        // Same packet shape against a stalled sink
        tname = "stall";
        axi_rdy = 1'b0;
        clr();
        add_src(1'b1, 1'b0, 32'hB000_0001, 2'd0, 1'b0);
        add_src(1'b0, 1'b0, 32'hB000_0002, 2'd0, 1'b0);
        add_src(1'b0, 1'b0, 32'hB000_0003, 2'd0, 1'b0);
        add_src(1'b0, 1'b0, 32'hB000_0004, 2'd0, 1'b0);
        add_src(1'b0, 1'b1, 32'hB000_0005, 2'd0, 1'b0);
        add_exp(32'hB000_0001, 4'hF, 1'b0, 1'b0);
        add_exp(32'hB000_0002, 4'hF, 1'b0, 1'b0);
        add_exp(32'hB000_0003, 4'hF, 1'b0, 1'b0);
        add_exp(32'hB000_0004, 4'hF, 1'b0, 1'b0);
        add_exp(32'hB000_0005, 4'hF, 1'b1, 1'b0);
        idle(10);
        chk("accepted", 32'(acc), 32'd4);
        chk("rdy_low_after", 32'(first_low_acc), 32'd2);
        chk("out_cnt_stalled", 32'(out_cnt), 32'd0);
        chk("head_valid", 32'(axi_valid), 32'd1);
        chk("head_data", axi_data, 32'hB000_0001);
        axi_rdy = 1'b1;
        run(40);
        idle(3);
        chk("out_cnt", 32'(out_cnt), 32'd5);
        chk("pe_cnt", 32'(pe_cnt), 32'd0);

        // Single-beat packet with error and empty=3
        tname = "single";
        clr();
        add_src(1'b1, 1'b1, 32'hC0C1_C2C3, 2'd3, 1'b1);
        add_exp(32'hC0C1_C2C3, 4'b1000, 1'b1, 1'b1);
        run(20);
        idle(3);
        chk("out_cnt", 32'(out_cnt), 32'd1);
        chk("pe_cnt", 32'(pe_cnt), 32'd0);
        chk("drop_cnt", 32'(drop_cnt), 32'd0);

        // Beats without sop while idle are dropped
        tname = "drop";
        clr();
        add_src(1'b0, 1'b0, 32'hDEAD_0001, 2'd0, 1'b0);
        add_src(1'b0, 1'b0, 32'hDEAD_0002, 2'd0, 1'b0);
        add_src(1'b0, 1'b1, 32'hDEAD_0003, 2'd2, 1'b1);
        run(20);
        idle(4);
        chk("out_cnt", 32'(out_cnt), 32'd0);
        chk("axi_valid", 32'(axi_valid), 32'd0);
        chk("drop_cnt", 32'(drop_cnt), 32'd3);
        chk("pe_cnt", 32'(pe_cnt), 32'd3);

        // sop after two beats truncates the packet; err on a non-eop beat is masked
        tname = "trunc";
        clr();
        add_src(1'b1, 1'b0, 32'hD000_0001, 2'd0, 1'b0);
        add_src(1'b0, 1'b0, 32'hD000_0002, 2'd0, 1'b1);
        add_src(1'b1, 1'b0, 32'hE000_0001, 2'd0, 1'b0);
        add_src(1'b0, 1'b0, 32'hE000_0002, 2'd0, 1'b0);
        add_src(1'b0, 1'b1, 32'hE000_0003, 2'd0, 1'b0);
        add_exp(32'hD000_0001, 4'hF, 1'b0, 1'b0);
        add_exp(32'hD000_0002, 4'hF, 1'b0, 1'b0);
        add_exp(32'hE000_0001, 4'hF, 1'b0, 1'b0);
        add_exp(32'hE000_0002, 4'hF, 1'b0, 1'b0);
        add_exp(32'hE000_0003, 4'hF, 1'b1, 1'b0);
        run(40);
        idle(3);
        chk("out_cnt", 32'(out_cnt), 32'd5);
        chk("pe_cnt", 32'(pe_cnt), 32'd1);
        chk("drop_cnt", 32'(drop_cnt), 32'd3);

        // Reset with three beats queued mid-packet
        tname = "midreset";
        axi_rdy = 1'b0;
        clr();
        add_src(1'b1, 1'b0, 32'hF000_0001, 2'd0, 1'b0);
        add_src(1'b0, 1'b0, 32'hF000_0002, 2'd0, 1'b0);
        add_src(1'b0, 1'b0, 32'hF000_0003, 2'd0, 1'b0);
        idle(6);
        chk("accepted", 32'(acc), 32'd3);
        chk("queued_valid", 32'(axi_valid), 32'd1);
        chk("queued_head", axi_data, 32'hF000_0001);
        rst_n = 1'b0;
        #1;
        chk("axi_valid", 32'(axi_valid), 32'd0);
        chk("drop_cnt", 32'(drop_cnt), 32'd0);
        chk("av_rdy", 32'(av_rdy), 32'd1);
        chk("axi_last", 32'(axi_last), 32'd0);
        src_q.delete();
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        tname = "postreset";
        axi_rdy = 1'b1;
        clr();
        add_src(1'b1, 1'b0, 32'h1234_5678, 2'd0, 1'b0);
        add_src(1'b0, 1'b1, 32'h9ABC_DEF0, 2'd2, 1'b0);
        add_exp(32'h1234_5678, 4'hF, 1'b0, 1'b0);
        add_exp(32'h9ABC_DEF0, 4'b1100, 1'b1, 1'b0);
        run(30);
        idle(3);
        chk("out_cnt", 32'(out_cnt), 32'd2);
        chk("pe_cnt", 32'(pe_cnt), 32'd0);
        chk("drop_cnt", 32'(drop_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
